// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) xtime, FSM encoding and 32-bit column access.
package aes_pkg;

  localparam int unsigned COL_W   = 32;
  localparam int unsigned STATE_W = 128;
  localparam int unsigned N_COLS  = 4;

  // Reduction polynomial x^8+x^4+x^3+x+1 without the x^8 term
  localparam logic [7:0] GF_POLY = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } imc_state_e;

  // Multiply by x in GF(2^8)
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Read column c; column 0 occupies the most significant word
  function automatic logic [COL_W-1:0] col_get(input logic [STATE_W-1:0] s,
                                               input logic [1:0]         c);
    logic [COL_W-1:0] v;
    case (c)
      2'd0:    v = s[127:96];
      2'd1:    v = s[95:64];
      2'd2:    v = s[63:32];
      default: v = s[31:0];
    endcase
    return v;
  endfunction

  // Return s with column c replaced by v
  function automatic logic [STATE_W-1:0] col_put(input logic [STATE_W-1:0] s,
                                                 input logic [1:0]         c,
                                                 input logic [COL_W-1:0]   v);
    logic [STATE_W-1:0] r;
    r = s;
    case (c)
      2'd0:    r[127:96] = v;
      2'd1:    r[95:64]  = v;
      2'd2:    r[63:32]  = v;
      default: r[31:0]   = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_mixcolumn.sv
// Combinational InvMixColumns of one 32-bit column (row 0 in the MSB byte).
module aes_inv_mixcolumn
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  output logic [COL_W-1:0] col_o
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] u, v;
  logic [7:0] b0, b1, b2, b3;
  logic [7:0] t;

  // Precondition with 4*(a0^a2) / 4*(a1^a3), then reuse the cheap forward MixColumn
  always_comb begin
    a0 = col_i[31:24];
    a1 = col_i[23:16];
    a2 = col_i[15:8];
    a3 = col_i[7:0];
    u  = xtime(xtime(a0 ^ a2));
    v  = xtime(xtime(a1 ^ a3));
    b0 = a0 ^ u;
    b1 = a1 ^ v;
    b2 = a2 ^ u;
    b3 = a3 ^ v;
    t  = b0 ^ b1 ^ b2 ^ b3;
    col_o = {b0 ^ t ^ xtime(b0 ^ b1),
             b1 ^ t ^ xtime(b1 ^ b2),
             b2 ^ t ^ xtime(b2 ^ b3),
             b3 ^ t ^ xtime(b3 ^ b0)};
  end

endmodule

// File: rtl/aes_inv_mixcolumns_iter.sv
// Iterative InvMixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock,
// valid/ready on both sides; the working register doubles as state_o.
module aes_inv_mixcolumns_iter
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] state_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_o
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("aes_inv_mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  // col_cnt value at the start of the edge that writes column 3
  localparam logic [1:0] CNT_LAST = 2'(N_COLS - COLS_PER_CYCLE);

  imc_state_e         state_q, state_d;
  logic [1:0]         col_cnt_q, col_cnt_d;
  logic [STATE_W-1:0] work_q, work_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [1:0]       col_idx [COLS_PER_CYCLE];
  logic [COL_W-1:0] col_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0] col_out [COLS_PER_CYCLE];

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_core
    assign col_idx[k] = col_cnt_q + 2'(k);
    assign col_in[k]  = col_get(work_q, col_idx[k]);
    aes_inv_mixcolumn u_core (
      .col_i (col_in[k]),
      .col_o (col_out[k])
    );
  end

  // Next-state, column write-back and handshake flags
  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    work_d      = work_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d     = state_i;
          col_cnt_d  = 2'd0;
          in_ready_d = 1'b0;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          work_d = col_put(work_d, col_idx[k], col_out[k]);
        end
        col_cnt_d = col_cnt_q + CNT_STEP;
        if (col_cnt_q == CNT_LAST) begin
          col_cnt_d   = 2'd0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        col_cnt_d   = 2'd0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_cnt_q   <= 2'd0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      work_q      <= work_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign state_o   = work_q;

endmodule
